// File: rtl/spi_burst_sequencer_if.sv
// Requester and SPI FIFO signals of the burst sequencer, bundled as one interface.
// slave is the sequencer's view; master is the environment (requester plus FIFOs).
interface spi_burst_sequencer_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [3:0] len;
  logic [7:0] wr_data;
  logic       wr_data_ack;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       cs_n;
  logic       wfwe;
  logic [7:0] wfdin;
  logic       wffull;
  logic       rfre;
  logic [7:0] rfdout;
  logic       rfempty;

  modport slave (
    input  start, rw, addr, len, wr_data, wffull, rfdout, rfempty,
    output wr_data_ack, rd_data, rd_valid, busy, done, cs_n, wfwe, wfdin, rfre
  );

  modport master (
    output start, rw, addr, len, wr_data, wffull, rfdout, rfempty,
    input  wr_data_ack, rd_data, rd_valid, busy, done, cs_n, wfwe, wfdin, rfre
  );
endinterface

// File: rtl/spi_burst_sequencer.sv
// Runs one SPI register-access burst (command, address, len data bytes) through
// the SPI write/read FIFOs and returns read bytes to the requester.
module spi_burst_sequencer #(
  parameter int unsigned CS_GAP    = 4,
  parameter logic [7:0]  CMD_WRITE = 8'h0A,
  parameter logic [7:0]  CMD_READ  = 8'h0B
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_burst_sequencer_if.slave  bus
);

  // IDLE wait start | FLUSH drop stale rx | SEND push byte | WAIT_RX wait echo | POP take rx | GAP cs_n high
  typedef enum logic [2:0] {IDLE, FLUSH, SEND, WAIT_RX, POP, GAP} state_t;

  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP);

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [3:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cs_n_q, cs_n_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  logic       wfwe_c, rfre_c, wr_data_ack_c;
  logic [7:0] wfdin_c;
  logic       data_phase, last_byte;

  assign data_phase = (idx_q >= 5'd2);
  assign last_byte  = (idx_q == ({1'b0, len_q} + 5'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      cs_n_q     <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      cs_n_q     <= cs_n_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    done_d        = 1'b0;
    wfwe_c        = 1'b0;
    wfdin_c       = 8'h00;
    rfre_c        = 1'b0;
    wr_data_ack_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done_q marks the first idle cycle, where a new start must still be refused
        if (bus.start && !done_q) begin
          rw_d    = bus.rw;
          addr_d  = bus.addr;
          len_d   = bus.len;
          idx_d   = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!bus.rfempty) rfre_c  = 1'b1;
        else              state_d = SEND;
      end
      SEND: begin
        if (idx_q == 5'd0)      wfdin_c = rw_q ? CMD_READ : CMD_WRITE;
        else if (idx_q == 5'd1) wfdin_c = addr_q;
        else                    wfdin_c = rw_q ? 8'h00 : bus.wr_data;
        if (!bus.wffull) begin
          wfwe_c        = 1'b1;
          wr_data_ack_c = !rw_q && data_phase;
          state_d       = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (!bus.rfempty) state_d = POP;
      end
      POP: begin
        rfre_c = 1'b1;
        if (rw_q && data_phase) begin
          rd_data_d  = bus.rfdout;
          rd_valid_d = 1'b1;
        end
        if (last_byte) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = SEND;
        end
      end
      GAP: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cs_n_d = !(state_d inside {FLUSH, SEND, WAIT_RX, POP});
    busy_d = (state_d != IDLE);
  end

  assign bus.wfwe        = wfwe_c;
  assign bus.wfdin       = wfdin_c;
  assign bus.rfre        = rfre_c;
  assign bus.wr_data_ack = wr_data_ack_c;
  assign bus.cs_n        = cs_n_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer: a small SPI/FIFO model echoes one read
// byte per written byte after a fixed shift delay; checks use hand-computed values.
module tb_spi_burst_sequencer;

  logic clk = 1'b0;
  logic rst;

  spi_burst_sequencer_if bus ();

  spi_burst_sequencer dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  // model/monitor state, written only by the model process
  logic [7:0] rfq[$];
  logic [7:0] wf_log[$];
  logic [7:0] rd_log[$];
  logic [7:0] ev_log[$];
  int n_wfwe = 0, n_rfre = 0, n_ack = 0, n_gap = 0, n_done = 0;
  int n_done_busy = 0, n_full_we = 0;
  int shift_cnt = 0, resp_idx = 0, resp_seen = 0, preload_seen = 0;

  // stimulus-owned tables
  logic [7:0] resp_tab[0:7];
  logic [7:0] preload_tab[0:1];
  int resp_gen = 0, preload_gen = 0, preload_n = 0;

  int n_chk = 0, n_err = 0;
  int b_wf, b_rfre, b_ack, b_rd, b_gap, b_done, b_ev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // SPI core + FIFO model: samples strobes at negedge, applies them after the next posedge
  initial begin
    bit do_pop, do_push;
    bus.rfempty = 1'b1;
    bus.rfdout  = 8'h00;
    forever begin
      @(negedge clk);
      do_pop  = 1'b0;
      do_push = 1'b0;
      if (!rst) begin
        if (bus.wfwe) begin
          do_push = 1'b1;
          n_wfwe++;
          wf_log.push_back(bus.wfdin);
          ev_log.push_back(8'h57);
          if (bus.wffull) n_full_we++;
        end
        if (bus.rfre) begin
          do_pop = 1'b1;
          n_rfre++;
          ev_log.push_back(8'h52);
        end
        if (bus.wr_data_ack) n_ack++;
        if (bus.rd_valid) rd_log.push_back(bus.rd_data);
        if (bus.cs_n && bus.busy) n_gap++;
        if (bus.done) begin
          n_done++;
          if (bus.busy) n_done_busy++;
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        rfq.delete();
        shift_cnt = 0;
      end else begin
        if (preload_gen != preload_seen) begin
          preload_seen = preload_gen;
          for (int i = 0; i < preload_n; i++) rfq.push_back(preload_tab[i]);
        end
        if (resp_gen != resp_seen) begin
          resp_seen = resp_gen;
          resp_idx  = 0;
        end
        if (do_pop && rfq.size() > 0) void'(rfq.pop_front());
        if (shift_cnt > 0) begin
          shift_cnt--;
          if (shift_cnt == 0) begin
            rfq.push_back(resp_idx < 8 ? resp_tab[resp_idx] : 8'hEE);
            resp_idx++;
          end
        end
        if (do_push) shift_cnt = 3;
      end
      bus.rfempty = (rfq.size() == 0);
      bus.rfdout  = (rfq.size() == 0) ? 8'h00 : rfq[0];
    end
  end

  task automatic snap();
    b_wf = wf_log.size(); b_rd = rd_log.size(); b_ev = ev_log.size();
    b_rfre = n_rfre; b_ack = n_ack; b_gap = n_gap; b_done = n_done;
  endtask

  task automatic set_resp(input logic [7:0] r0, r1, r2, r3, r4);
    resp_tab[0] = r0; resp_tab[1] = r1; resp_tab[2] = r2;
    resp_tab[3] = r3; resp_tab[4] = r4;
    for (int i = 5; i < 8; i++) resp_tab[i] = 8'hEE;
    resp_gen++;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic start_burst(input string tag, input logic r, input logic [7:0] a,
                             input logic [3:0] l, input logic [7:0] d);
    bus.rw = r; bus.addr = a; bus.len = l; bus.wr_data = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy_after_start"}, bus.busy, 1'b1);
    chk({tag, "_cs_n_after_start"}, bus.cs_n, 1'b0);
  endtask

  task automatic wait_wfwe(input string tag, input int target);
    int k = 0;
    while (n_wfwe < target && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_wfwe_reached"}, n_wfwe >= target, 1'b1);
  endtask

  task automatic wait_done(input string tag, input bit inject);
    int k = 0;
    while (!bus.done && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_done_seen"}, bus.done, 1'b1);
    if (inject) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, "_start_in_done_cycle_ignored"}, bus.busy, 1'b0);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = 8'h00; bus.len = 4'd0;
    bus.wr_data = 8'h00; bus.wffull = 1'b0;
    for (int i = 0; i < 8; i++) resp_tab[i] = 8'hEE;
    preload_tab[0] = 8'h00; preload_tab[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", bus.cs_n, 1'b1);
    chk("rst_wfwe", bus.wfwe, 1'b0);
    chk("rst_rfre", bus.rfre, 1'b0);
    chk("rst_wfdin", bus.wfdin, 8'h00);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_ack", bus.wr_data_ack, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // write burst: 0A 1F 52
    set_resp(8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    snap();
    start_burst("wr", 1'b0, 8'h1F, 4'd1, 8'h52);
    wait_done("wr", 1'b1);
    chk("wr_nbytes", wf_log.size() - b_wf, 3);
    chk("wr_byte0", wf_log[b_wf], 8'h0A);
    chk("wr_byte1", wf_log[b_wf+1], 8'h1F);
    chk("wr_byte2", wf_log[b_wf+2], 8'h52);
    chk("wr_rfre", n_rfre - b_rfre, 3);
    chk("wr_ack", n_ack - b_ack, 1);
    chk("wr_rd_valid", rd_log.size() - b_rd, 0);
    chk("wr_gap", n_gap - b_gap, 4);
    chk("wr_done_count", n_done - b_done, 1);
    chk("wr_busy_at_done", n_done_busy, 0);

    // read burst: 0B 08 00 00 00, returns 11 22 33
    set_resp(8'hA1, 8'hA2, 8'h11, 8'h22, 8'h33);
    snap();
    start_burst("rd", 1'b1, 8'h08, 4'd3, 8'hFF);
    wait_done("rd", 1'b0);
    chk("rd_nbytes", wf_log.size() - b_wf, 5);
    chk("rd_byte0", wf_log[b_wf], 8'h0B);
    chk("rd_byte1", wf_log[b_wf+1], 8'h08);
    chk("rd_byte2", wf_log[b_wf+2], 8'h00);
    chk("rd_byte3", wf_log[b_wf+3], 8'h00);
    chk("rd_byte4", wf_log[b_wf+4], 8'h00);
    chk("rd_nvalid", rd_log.size() - b_rd, 3);
    chk("rd_data0", rd_log[b_rd], 8'h11);
    chk("rd_data1", rd_log[b_rd+1], 8'h22);
    chk("rd_data2", rd_log[b_rd+2], 8'h33);
    chk("rd_ack", n_ack - b_ack, 0);
    chk("rd_rfre", n_rfre - b_rfre, 5);
    chk("rd_gap", n_gap - b_gap, 4);

    // backpressure on the data byte
    set_resp(8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    snap();
    start_burst("bp", 1'b0, 8'h3C, 4'd1, 8'hA5);
    wait_wfwe("bp", b_wf + 2);
    bus.wffull = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("bp_no_send_while_full", wf_log.size() - b_wf, 2);
    chk("bp_no_ack_while_full", n_ack - b_ack, 0);
    bus.wffull = 1'b0;
    wait_done("bp", 1'b0);
    chk("bp_wfwe_while_full", n_full_we, 0);
    chk("bp_nbytes", wf_log.size() - b_wf, 3);
    chk("bp_data", wf_log[b_wf+2], 8'hA5);
    chk("bp_ack", n_ack - b_ack, 1);

    // stale bytes in the read FIFO before start
    preload_tab[0] = 8'hDE; preload_tab[1] = 8'hAD; preload_n = 2;
    preload_gen++;
    set_resp(8'hB1, 8'hB2, 8'h5C, 8'hEE, 8'hEE);
    snap();
    start_burst("fl", 1'b1, 8'h2A, 4'd1, 8'h00);
    wait_done("fl", 1'b0);
    chk("fl_ev0_rfre", ev_log[b_ev], 8'h52);
    chk("fl_ev1_rfre", ev_log[b_ev+1], 8'h52);
    chk("fl_ev2_wfwe", ev_log[b_ev+2], 8'h57);
    chk("fl_rfre", n_rfre - b_rfre, 5);
    chk("fl_nvalid", rd_log.size() - b_rd, 1);
    chk("fl_data", rd_log[b_rd], 8'h5C);

    // start while busy is ignored
    set_resp(8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    snap();
    start_burst("sb", 1'b0, 8'h30, 4'd2, 8'h66);
    wait_wfwe("sb", b_wf + 1);
    bus.rw = 1'b1; bus.addr = 8'h77; bus.len = 4'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("sb", 1'b0);
    chk("sb_nbytes", wf_log.size() - b_wf, 4);
    chk("sb_cmd", wf_log[b_wf], 8'h0A);
    chk("sb_addr", wf_log[b_wf+1], 8'h30);
    chk("sb_data", wf_log[b_wf+3], 8'h66);
    chk("sb_done_count", n_done - b_done, 1);
    chk("sb_ack", n_ack - b_ack, 2);

    // async reset during WAIT_RX of a len=4 read
    set_resp(8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    start_burst("mr", 1'b1, 8'h10, 4'd4, 8'h00);
    wait_wfwe("mr", wf_log.size() + 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_cs_n", bus.cs_n, 1'b1);
    chk("mr_wfwe", bus.wfwe, 1'b0);
    chk("mr_rfre", bus.rfre, 1'b0);
    chk("mr_ack", bus.wr_data_ack, 1'b0);
    chk("mr_rd_valid", bus.rd_valid, 1'b0);
    chk("mr_busy", bus.busy, 1'b0);
    chk("mr_done", bus.done, 1'b0);
    chk("mr_wfdin", bus.wfdin, 8'h00);
    chk("mr_rd_data", bus.rd_data, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mr_idle_busy", bus.busy, 1'b0);
    chk("mr_idle_cs_n", bus.cs_n, 1'b1);
    set_resp(8'hC1, 8'hC2, 8'hEE, 8'hEE, 8'hEE);
    snap();
    start_burst("pr", 1'b0, 8'h44, 4'd0, 8'h99);
    wait_done("pr", 1'b0);
    chk("pr_nbytes", wf_log.size() - b_wf, 2);
    chk("pr_cmd", wf_log[b_wf], 8'h0A);
    chk("pr_addr", wf_log[b_wf+1], 8'h44);
    chk("pr_rfre", n_rfre - b_rfre, 2);
    chk("pr_ack", n_ack - b_ack, 0);
    chk("pr_nvalid", rd_log.size() - b_rd, 0);
    chk("pr_done_count", n_done - b_done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
